serial_sub8: RTL and testbench
==============================

Name: serial_sub8

Overview:
Bit-serial subtractor. It computes A - B - Bin one bit per clock, LSB first, using a single one-bit full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's ripple-carry adder, built for area-constrained datapaths. Operands are taken in and results handed out through valid/ready handshakes.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands A, B, Bin are valid
in_ready  output  1  block can accept operands
A  input  WIDTH  minuend
B  input  WIDTH  subtrahend
Bin  input  1  borrow in
out_valid  output  1  D, Bout, ovfl, Z, LT are valid
out_ready  input  1  consumer accepts the result
D  output  WIDTH  difference, (A - B - Bin) mod 2^WIDTH
Bout  output  1  unsigned borrow out: 1 iff A < B + Bin
ovfl  output  1  two's-complement overflow: A[msb]!=B[msb] and D[msb]!=A[msb]
Z  output  1  D == 0 (compare feature only)
LT  output  1  signed A < B + Bin, computed as D[msb] ^ ovfl (compare feature only)

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, D=0, Bout=0, ovfl=0, Z=0, LT=0. Internal shift registers, bit counter and borrow flip-flop are all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch A, B and Bin (Bin goes into the borrow flip-flop), clear the bit counter and go to SHIFT.
- SHIFT:
  - in_ready=0; in_valid is ignored.
  - Each edge processes bit i, where i is the counter value:
    - d_i = a_i ^ b_i ^ brw
    - brw' = (~a_i & b_i) | (~(a_i ^ b_i) & brw)
  - d_i shifts into D from the MSB side. The counter increments.
  - On the edge that processes bit WIDTH-1:
    - capture Bout = brw'
    - capture ovfl from A[msb], B[msb] and d_msb
    - go to DONE
- DONE:
  - out_valid=1. D, Bout, ovfl, Z and LT are held stable.
  - On an edge with out_ready=1, go to IDLE, and out_valid falls.
  - Outputs keep their values until the next operation completes. D is not cleared.
- Latency: out_valid rises on the WIDTH-th rising edge after the accepting edge (8 for the default).
- Throughput: minimum accept-to-accept spacing is WIDTH+2 edges. There is no same-cycle accept in DONE.
- D is updated only on the final SHIFT edge. It shifts in an internal register, so D never shows a partial result.
- Backpressure: out_ready=0 in DONE holds the state indefinitely with no change to any output.
- Reset mid-operation (SHIFT or DONE): the operation is aborted and every output takes its reset value immediately.
- Wrap-around: results are modulo 2^WIDTH. Bout and ovfl are the only out-of-range indicators.

Optional Feature:
SERIAL_SUB_CMP_EN
- Defined: Z and LT are computed and registered together with Bout on the final SHIFT edge.
- Undefined: Z and LT are tied to 0 and no compare logic is synthesised.
- The port list is identical in both cases.

Decomposition:
- Shared package: FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a DEFAULT_WIDTH=8 constant.
- One sub-module, full_sub: combinational 1-bit full subtractor.
  - Inputs a, b, bin.
  - Outputs d, bout.
  - Instantiated once in the serial datapath.

Test Plan:
1. A=0x05, B=0x03, Bin=0 → D=0x02, Bout=0, ovfl=0. out_valid rises exactly 8 edges after the accepting edge.
2. A=0x00, B=0x01, Bin=0 → D=0xFF, Bout=1, ovfl=0. With the macro defined: LT=1, Z=0.
3. A=0x80, B=0x01, Bin=0 → D=0x7F, Bout=0, ovfl=1. Also A=0x7F, B=0xFF, Bin=0 → D=0x80, Bout=1, ovfl=1.
4. A=0x10, B=0x0F, Bin=1 → D=0x00, Bout=0. Z=1 with the macro defined, Z=0 without.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands during SHIFT and DONE → outputs stable, in_ready=0, and no new operation starts. Then out_ready=1 → IDLE, in_ready=1.
6. Assert rst asynchronously (between clock edges) at the 4th SHIFT edge → all outputs go to reset values immediately. After release, a fresh A=0x03, B=0x05 gives D=0xFE, Bout=1.

Source files
------------

// File: rtl/serial_sub8_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings, default width
// and the two's-complement overflow helper.
package serial_sub8_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Overflow of a - b: operand signs differ and the result sign differs from the minuend.
    function automatic logic sub_ovfl(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_sub8_full_sub.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor computing A - B - Bin LSB first with valid/ready handshakes.
// Optional compare flags Z/LT are enabled by defining SERIAL_SUB_CMP_EN.
module serial_sub8
    import serial_sub8_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             ovfl,
    output logic             Z,
    output logic             LT
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-2:0] d_sh_r;
    logic [CW-1:0]    cnt_r;
    logic             brw_r;

    logic             d_bit_s;
    logic             brw_next_s;
    logic             last_s;
    logic             ovfl_next_s;
    logic [WIDTH-1:0] d_next_s;

    full_sub u_cell (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (brw_r),
        .d    (d_bit_s),
        .bout (brw_next_s)
    );

    // The partial difference never reaches D; only the completed word is copied out.
    assign d_next_s    = {d_bit_s, d_sh_r};
    assign last_s      = (cnt_r == CW'(WIDTH - 1));
    assign ovfl_next_s = sub_ovfl(a_r[0], b_r[0], d_bit_s);

    // Control FSM, serial datapath and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            d_sh_r    <= {(WIDTH-1){1'b0}};
            cnt_r     <= {CW{1'b0}};
            brw_r     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D         <= {WIDTH{1'b0}};
            Bout      <= 1'b0;
            ovfl      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r      <= A;
                        b_r      <= B;
                        brw_r    <= Bin;
                        cnt_r    <= {CW{1'b0}};
                        in_ready <= 1'b0;
                        state_r  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_r    <= {1'b0, a_r[WIDTH-1:1]};
                    b_r    <= {1'b0, b_r[WIDTH-1:1]};
                    brw_r  <= brw_next_s;
                    d_sh_r <= d_next_s[WIDTH-1:1];
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_s) begin
                        D         <= d_next_s;
                        Bout      <= brw_next_s;
                        ovfl      <= ovfl_next_s;
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_CMP_EN
    logic z_next_s;
    logic lt_next_s;

    assign z_next_s  = (d_next_s == {WIDTH{1'b0}});
    assign lt_next_s = d_bit_s ^ ovfl_next_s;

    // Compare flags captured alongside Bout on the final serial step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Z  <= 1'b0;
            LT <= 1'b0;
        end else if ((state_r == ST_SHIFT) && last_s) begin
            Z  <= z_next_s;
            LT <= lt_next_s;
        end
    end
`else
    assign Z  = 1'b0;
    assign LT = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: directed vectors push expected results,
// an independent monitor checks each result on its output handshake.
module tb_serial_sub8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bout;
    logic         ovfl;
    logic         Z;
    logic         LT;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ovfl;
        logic         z;
        logic         lt;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_sub8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .ovfl      (ovfl),
        .Z         (Z),
        .LT        (LT)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic cmp_exp(input logic v);
`ifdef SERIAL_SUB_CMP_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic bo, input logic ov,
                            input logic z, input logic lt);
        exp_t e;
        e.d    = d;
        e.bout = bo;
        e.ovfl = ov;
        e.z    = cmp_exp(z);
        e.lt   = cmp_exp(lt);
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_issue", in_ready, 1);
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] d, input logic bo, input logic ov,
                          input logic z, input logic lt);
        int lat;
        push_exp(d, bo, ov, z, lt);
        issue(a, b, bin);
        wait_valid(lat);
        check("latency", lat, W);
        tick();
    endtask

    // Monitor: pop and compare on every accepted output handshake.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result D=0x%0h, expected no result", D);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_D",    D,    e.d);
                check("sb_Bout", Bout, e.bout);
                check("sb_ovfl", ovfl, e.ovfl);
                check("sb_Z",    Z,    e.z);
                check("sb_LT",   LT,   e.lt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = 8'h00;
        B         = 8'h00;
        Bin       = 1'b0;
        #12;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_D",         D,         0);
        check("rst_Bout",      Bout,      0);
        check("rst_ovfl",      ovfl,      0);
        check("rst_Z",         Z,         0);
        check("rst_LT",        LT,        0);
        tick();
        rst = 1'b0;
        tick();

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // Backpressure with in_valid pulses during SHIFT and DONE.
        out_ready = 1'b0;
        push_exp(8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(8'hAA, 8'h55, 1'b0);
        for (int i = 0; i < 3; i++) begin
            A        = 8'h11;
            B        = 8'h22;
            in_valid = 1'b1;
            check("bp_shift_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        begin
            int lat;
            wait_valid(lat);
        end
        for (int i = 0; i < 5; i++) begin
            A        = 8'h0F;
            B        = 8'h01;
            in_valid = 1'b1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready",  in_ready,  0);
            check("bp_D",         D,         8'h55);
            check("bp_Bout",      Bout,      0);
            check("bp_ovfl",      ovfl,      1);
            check("bp_Z",         Z,         cmp_exp(1'b0));
            check("bp_LT",        LT,        cmp_exp(1'b1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready",  in_ready,  1);
        check("bp_release_out_valid", out_valid, 0);
        tick();
        tick();
        check("bp_no_new_op", out_valid, 0);

        // Asynchronous reset between edges after the 4th serial step.
        issue(8'h5A, 8'h33, 1'b0);
        tick();
        tick();
        tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready",  in_ready,  1);
        check("arst_out_valid", out_valid, 0);
        check("arst_D",         D,         0);
        check("arst_Bout",      Bout,      0);
        check("arst_ovfl",      ovfl,      0);
        check("arst_Z",         Z,         0);
        check("arst_LT",        LT,        0);
        tick();
        rst = 1'b0;
        tick();
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);

        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
